// File: rtl/store_buffer_if.sv
// store_buffer_if: pipeline store/load-check port and data-memory write port of the store buffer
interface store_buffer_if;
  logic        st_valid;
  logic        st_ready;
  logic [2:0]  st_funct3;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_err;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic        dmem_resp;
  logic        empty;
  modport master (
    output st_valid, st_funct3, st_addr, st_data, ld_addr, dmem_resp,
    input  st_ready, st_err, ld_hit, dmem_write, dmem_address, dmem_wdata, dmem_mbe, empty
  );
  modport slave (
    input  st_valid, st_funct3, st_addr, st_data, ld_addr, dmem_resp,
    output st_ready, st_err, ld_hit, dmem_write, dmem_address, dmem_wdata, dmem_mbe, empty
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO that encodes SB/SH/SW stores and drains them to data memory
module store_buffer #(
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic rst,
  store_buffer_if.slave sb
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic {IDLE, WRITE} state_t;
  state_t state;
  logic [AW-1:0] head, tail, off;
  logic [CW-1:0] count;
  logic [29:0] addr_q [DEPTH];
  logic [3:0] mbe_q [DEPTH];
  logic [31:0] wdata_q [DEPTH];
  logic [1:0] a;
  logic ok, accept, push, pop, err_q, hit;
  logic [3:0] mask;
  logic [31:0] wdata;
  assign a = sb.st_addr[1:0];
  assign ok = sb.st_funct3 == 3'b000 || (sb.st_funct3 == 3'b001 && !a[0]) || (sb.st_funct3 == 3'b010 && a == 2'b00);
  assign mask = sb.st_funct3 == 3'b000 ? 4'b0001 << a : sb.st_funct3 == 3'b001 ? 4'b0011 << a : 4'b1111;
  assign wdata = sb.st_funct3 == 3'b000 ? {4{sb.st_data[7:0]}} : sb.st_funct3 == 3'b001 ? {2{sb.st_data[15:0]}} : sb.st_data;
  assign sb.st_ready = count < CW'(DEPTH);
  assign accept = sb.st_valid && sb.st_ready;
  assign push = accept && ok;
  assign pop = state == WRITE && sb.dmem_resp;
  assign sb.st_err = err_q;
  assign sb.empty = count == '0 && state == IDLE;
  assign sb.dmem_write = state == WRITE;
  assign sb.dmem_address = {addr_q[head], 2'b00};
  assign sb.dmem_mbe = mbe_q[head];
  assign sb.dmem_wdata = wdata_q[head];
  assign sb.ld_hit = hit;
  // a slot is live when its distance from head is below count; any live word match flags the load
  always_comb begin
    hit = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - head;
      hit = hit | (CW'(off) < count && addr_q[i] == sb.ld_addr[31:2]);
    end
  end
  // drain FSM, FIFO pointers/count and the one-cycle drop pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      head <= '0;
      tail <= '0;
      count <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= accept && !ok;
      count <= count + CW'(push) - CW'(pop);
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      state <= state == IDLE ? (count != '0 ? WRITE : IDLE) : (sb.dmem_resp ? IDLE : WRITE);
    end
  end
  // entry payload written at the tail; validity comes from count, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= sb.st_addr[31:2];
      mbe_q[tail] <= mask;
      wdata_q[tail] <= wdata;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: table vectors, corner-case sequences and random stimulus against a queue model
module tb_store_buffer;
  localparam int DEPTH = 2;
  localparam int NV = 12;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;
  store_buffer_if bus();
  store_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .sb(bus.slave));
  always #5 clk = ~clk;
  typedef struct { logic [31:0] a; logic [3:0] m; logic [31:0] w; } ent_t;
  typedef struct {
    logic [2:0] f; logic [31:0] a; logic [31:0] d;
    logic err; logic [31:0] ea; logic [3:0] em; logic [31:0] ew;
  } vec_t;
  ent_t mq[$];
  bit m_wr, m_err;
  vec_t vt[NV];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    bus.st_valid = v;
    bus.st_funct3 = f;
    bus.st_addr = a;
    bus.st_data = d;
  endtask

  function automatic bit encode(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d, output ent_t e);
    int o;
    o = int'(a % 4);
    e.a = a - a % 4;
    e.m = 4'd0;
    e.w = 32'd0;
    if (f == 3'd0) begin
      e.m = 4'(1 << o);
      e.w = (d % 256) * 32'h0101_0101;
      return 1'b1;
    end
    if (f == 3'd1) begin
      e.m = 4'(3 << o);
      e.w = (d % 65536) * 32'h0001_0001;
      return o % 2 == 0;
    end
    if (f == 3'd2) begin
      e.m = 4'hF;
      e.w = d;
      return o == 0;
    end
    return 1'b0;
  endfunction

  task automatic check_all();
    bit h;
    h = 1'b0;
    foreach (mq[i]) if ((mq[i].a >> 2) == (bus.ld_addr >> 2)) h = 1'b1;
    chk("st_ready", bus.st_ready, mq.size() < DEPTH);
    chk("dmem_write", bus.dmem_write, m_wr);
    chk("empty", bus.empty, mq.size() == 0 && !m_wr);
    chk("st_err", bus.st_err, m_err);
    chk("ld_hit", bus.ld_hit, h);
    if (m_wr) begin
      chk("dmem_address", bus.dmem_address, mq[0].a);
      chk("dmem_mbe", bus.dmem_mbe, mq[0].m);
      chk("dmem_wdata", bus.dmem_wdata, mq[0].w);
    end
  endtask

  task automatic tick();
    ent_t e;
    bit ok, acc, nw;
    if (!rst) begin
      mq.delete();
      m_wr = 1'b0;
      m_err = 1'b0;
    end else begin
      ok = encode(bus.st_funct3, bus.st_addr, bus.st_data, e);
      acc = bus.st_valid && mq.size() < DEPTH;
      nw = m_wr ? !bus.dmem_resp : mq.size() > 0;
      if (m_wr && bus.dmem_resp) void'(mq.pop_front());
      if (acc && ok) mq.push_back(e);
      m_err = acc && !ok;
      m_wr = nw;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    vt[0]  = '{3'b000, 32'h0000_1003, 32'hAABB_CCDD, 1'b0, 32'h0000_1000, 4'b1000, 32'hDDDD_DDDD};
    vt[1]  = '{3'b000, 32'h0000_1000, 32'hAABB_CCDD, 1'b0, 32'h0000_1000, 4'b0001, 32'hDDDD_DDDD};
    vt[2]  = '{3'b000, 32'h0000_1001, 32'h1122_3344, 1'b0, 32'h0000_1000, 4'b0010, 32'h4444_4444};
    vt[3]  = '{3'b000, 32'h0000_1002, 32'h1122_3399, 1'b0, 32'h0000_1000, 4'b0100, 32'h9999_9999};
    vt[4]  = '{3'b001, 32'h0000_2002, 32'h1234_5678, 1'b0, 32'h0000_2000, 4'b1100, 32'h5678_5678};
    vt[5]  = '{3'b001, 32'h0000_2000, 32'hCAFE_BABE, 1'b0, 32'h0000_2000, 4'b0011, 32'hBABE_BABE};
    vt[6]  = '{3'b010, 32'h0000_2004, 32'h1234_5678, 1'b0, 32'h0000_2004, 4'b1111, 32'h1234_5678};
    vt[7]  = '{3'b010, 32'h0000_3001, 32'h1111_1111, 1'b1, 32'h0, 4'b0, 32'h0};
    vt[8]  = '{3'b001, 32'h0000_3003, 32'h2222_2222, 1'b1, 32'h0, 4'b0, 32'h0};
    vt[9]  = '{3'b011, 32'h0000_3000, 32'h3333_3333, 1'b1, 32'h0, 4'b0, 32'h0};
    vt[10] = '{3'b001, 32'h0000_3001, 32'h4444_4444, 1'b1, 32'h0, 4'b0, 32'h0};
    vt[11] = '{3'b111, 32'h0000_3004, 32'h5555_5555, 1'b1, 32'h0, 4'b0, 32'h0};
    drive(0, 3'd0, 32'd0, 32'd0);
    bus.ld_addr = 32'd0;
    bus.dmem_resp = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    chk("rst_dmem_write", bus.dmem_write, 0);
    chk("rst_st_err", bus.st_err, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_st_ready", bus.st_ready, 1);
    chk("rst_ld_hit", bus.ld_hit, 0);
    rst = 1'b1;
    tick();
    for (int i = 0; i < NV; i++) begin
      drive(1, vt[i].f, vt[i].a, vt[i].d);
      tick();
      drive(0, 3'd0, 32'd0, 32'd0);
      chk($sformatf("vec%0d_err", i), bus.st_err, vt[i].err);
      tick();
      if (!vt[i].err) begin
        chk($sformatf("vec%0d_write", i), bus.dmem_write, 1);
        chk($sformatf("vec%0d_addr", i), bus.dmem_address, vt[i].ea);
        chk($sformatf("vec%0d_mbe", i), bus.dmem_mbe, vt[i].em);
        chk($sformatf("vec%0d_wdata", i), bus.dmem_wdata, vt[i].ew);
        bus.dmem_resp = 1'b1;
        tick();
        bus.dmem_resp = 1'b0;
      end else begin
        chk($sformatf("vec%0d_err_pulse", i), bus.st_err, 0);
        chk($sformatf("vec%0d_nowrite", i), bus.dmem_write, 0);
      end
      chk($sformatf("vec%0d_empty", i), bus.empty, 1);
    end
    drive(1, 3'd0, 32'h0000_1003, 32'hAABB_CCDD);
    tick();
    drive(0, 3'd0, 32'd0, 32'd0);
    chk("sb_e0_write", bus.dmem_write, 0);
    tick();
    chk("sb_e1_write", bus.dmem_write, 1);
    chk("sb_e1_addr", bus.dmem_address, 32'h0000_1000);
    tick();
    chk("sb_e2_write", bus.dmem_write, 1);
    tick();
    chk("sb_e3_write", bus.dmem_write, 1);
    bus.dmem_resp = 1'b1;
    tick();
    bus.dmem_resp = 1'b0;
    chk("sb_e4_write", bus.dmem_write, 0);
    drive(1, 3'd1, 32'h0000_2002, 32'h1234_5678);
    tick();
    drive(1, 3'd2, 32'h0000_2004, 32'h1234_5678);
    tick();
    drive(0, 3'd0, 32'd0, 32'd0);
    chk("shsw_sh_mbe", bus.dmem_mbe, 4'b1100);
    chk("shsw_sh_wdata", bus.dmem_wdata, 32'h5678_5678);
    bus.dmem_resp = 1'b1;
    tick();
    bus.dmem_resp = 1'b0;
    chk("shsw_gap", bus.dmem_write, 0);
    tick();
    chk("shsw_sw_write", bus.dmem_write, 1);
    chk("shsw_sw_addr", bus.dmem_address, 32'h0000_2004);
    chk("shsw_sw_mbe", bus.dmem_mbe, 4'b1111);
    bus.dmem_resp = 1'b1;
    tick();
    bus.dmem_resp = 1'b0;
    drive(1, 3'd2, 32'h0000_6000, 32'hA);
    tick();
    drive(1, 3'd2, 32'h0000_6004, 32'hB);
    tick();
    chk("full_ready", bus.st_ready, 0);
    drive(1, 3'd2, 32'h0000_6008, 32'hC);
    bus.dmem_resp = 1'b1;
    tick();
    bus.dmem_resp = 1'b0;
    chk("full_not_taken", bus.st_ready, 1);
    tick();
    drive(0, 3'd0, 32'd0, 32'd0);
    chk("full_taken", bus.st_ready, 0);
    chk("full_b_addr", bus.dmem_address, 32'h0000_6004);
    bus.dmem_resp = 1'b1;
    tick();
    bus.dmem_resp = 1'b0;
    tick();
    chk("full_c_addr", bus.dmem_address, 32'h0000_6008);
    chk("full_c_wdata", bus.dmem_wdata, 32'hC);
    bus.dmem_resp = 1'b1;
    tick();
    bus.dmem_resp = 1'b0;
    chk("full_empty", bus.empty, 1);
    drive(1, 3'd2, 32'h0000_4008, 32'h55);
    tick();
    drive(0, 3'd0, 32'd0, 32'd0);
    bus.ld_addr = 32'h0000_400B;
    #1;
    chk("ld_hit_same_word", bus.ld_hit, 1);
    bus.ld_addr = 32'h0000_400C;
    #1;
    chk("ld_hit_next_word", bus.ld_hit, 0);
    bus.ld_addr = 32'h0000_400B;
    tick();
    chk("ld_hit_writing", bus.ld_hit, 1);
    bus.dmem_resp = 1'b1;
    tick();
    bus.dmem_resp = 1'b0;
    chk("ld_hit_after_pop", bus.ld_hit, 0);
    drive(1, 3'd2, 32'h0000_7000, 32'h1);
    tick();
    drive(1, 3'd2, 32'h0000_7004, 32'h2);
    tick();
    drive(0, 3'd0, 32'd0, 32'd0);
    chk("rstw_write", bus.dmem_write, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rstw_write_low", bus.dmem_write, 0);
    chk("rstw_empty", bus.empty, 1);
    chk("rstw_ready", bus.st_ready, 1);
    bus.dmem_resp = 1'b1;
    tick();
    bus.dmem_resp = 1'b0;
    tick();
    chk("rstw_resp_ignored", bus.dmem_write, 0);
    repeat (3000) begin
      drive(1'($urandom % 2),
            ($urandom % 8 < 6) ? 3'($urandom % 3) : 3'($urandom % 8),
            32'h0000_5000 + ($urandom % 32), $urandom);
      bus.ld_addr = 32'h0000_5000 + ($urandom % 32);
      bus.dmem_resp = ($urandom % 3) == 0;
      rst = ($urandom % 150) != 0;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write store buffer between the execute/memory stage and the data-memory port. Accepts SB/SH/SW requests from the pipeline, converts each into a word-aligned address, byte mask and lane-replicated write data, queues them in a small FIFO, and drains them to data memory with a request/response handshake. It produces the aligned write stream that load extraction (lb/lbu/lh/lhu/lw) later reads back. It also flags loads that conflict with pending stores, so the pipeline can stall them.

## Interface
- `DEPTH`, 2: FIFO entries; power of two, ≥2.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `st_valid`  in  1  store request present.
- `st_ready`  out  1  buffer can accept; equals `count < DEPTH`.
- `st_funct3`  in  3  000 = SB, 001 = SH, 010 = SW; any other value is illegal.
- `st_addr`  in  32  byte address (ALU output).
- `st_data`  in  32  store data (rs2 value).
- `st_err`  out  1  one-cycle pulse, registered: previous accepted request was misaligned or illegal and was dropped.
- `ld_addr`  in  32  address of the load in the memory stage.
- `ld_hit`  out  1  combinational: a queued entry matches `ld_addr[31:2]`.
- `dmem_write`  out  1  write request to data memory.
- `dmem_address`  out  32  word-aligned address, low 2 bits = 0.
- `dmem_wdata`  out  32  lane-replicated write data.
- `dmem_mbe`  out  4  byte enables.
- `dmem_resp`  in  1  memory completed the current write.
- `empty`  out  1  `count == 0` and state is IDLE.

## Operation
- **Accept.** A request is accepted on an edge where `st_valid && st_ready`. `st_ready` does not look at a same-cycle pop, so there is no full-bypass path.
- **Encode** (a = `st_addr[1:0]`):
  - SB: mask = `4'b0001 << a`; wdata = `{4{st_data[7:0]}}`. Any `a` is legal.
  - SH: mask = `4'b0011 << a`; wdata = `{2{st_data[15:0]}}`. Misaligned if `a[0]` = 1.
  - SW: mask = `4'b1111`; wdata = `st_data`. Misaligned if `a` ≠ 0.
- **Error handling.** A misaligned or illegal request is still accepted (handshake completes) but is not enqueued. `st_err` goes high for exactly the following cycle.
- **Entry contents.** Each entry holds the word address `{st_addr[31:2], 2'b00}`, the mask and the wdata. Storage is a circular FIFO with head/tail pointers that wrap modulo `DEPTH`, plus a count.
- **Drain FSM.** States are IDLE and WRITE.
  - IDLE → WRITE when `count > 0`.
  - In WRITE, `dmem_write` = 1 and the `dmem_*` outputs show the head entry, held stable until `dmem_resp`.
  - On an edge with `dmem_resp` in WRITE: pop the head, advance head, go to IDLE.
  - `dmem_resp` is ignored while in IDLE.
- **Simultaneous push and pop.** Count is unchanged and both pointers advance.
- **Data outputs when idle.** `dmem_write` = 0. `dmem_address`, `dmem_wdata` and `dmem_mbe` still show the head entry but are don't-care.
- **Load conflict.** `ld_hit` = 1 if any valid entry, including the one currently being written, has a word address equal to `ld_addr[31:2]`. There is no forwarding; the pipeline stalls the load until `ld_hit` = 0.
- **Reset** (`rst` = 0 at an edge):
  - count = 0, head = tail = 0, state = IDLE.
  - Outputs: `dmem_write` = 0, `st_err` = 0, `empty` = 1, `st_ready` = 1, `ld_hit` = 0.
  - A write in flight is abandoned. Data memory must tolerate `dmem_write` dropping without `dmem_resp`.

## Timing
- **Enqueue to memory.** A store accepted at edge E0 into an empty buffer gives IDLE→WRITE at E1, so `dmem_write` is high from E1.
- **Memory response.** `dmem_resp` sampled high at edge Ek pops the entry, and `dmem_write` is low in the cycle after Ek.
- **Next entry.** If entries remain, WRITE is re-entered at Ek+1.
- **Gap between writes.** `dmem_write` is low for exactly one cycle between consecutive writes.
- **Throughput.** One store per (memory latency + 1) cycles.
- **`st_ready` and `empty`.** Both derive only from registered state, so they have no combinational path from `st_valid`.
- **`ld_hit`.** Combinational from `ld_addr` and registered entries only. A store accepted at the same edge is visible to `ld_hit` from the next cycle onward.
- **`st_err`.** Registered; asserted in the cycle after the accepting edge.

## Test plan
- **SB lanes.** SB with addr 0x0000_1003, data 0xAABB_CCDD, resp 2 cycles later → `dmem_address` = 0x0000_1000, `dmem_mbe` = 4'b1000, `dmem_wdata` = 0xDDDD_DDDD. `dmem_write` high for 3 cycles starting 1 cycle after accept.
- **SH and SW.** SH at 0x2002 with data 0x1234_5678 → mbe 4'b1100, wdata 0x5678_5678. SW at 0x2004 → mbe 4'b1111, wdata unchanged. Writes must issue in order, with a 1-cycle `dmem_write` gap between them.
- **Misaligned and illegal.** SW at 0x3001, SH at 0x3003 and funct3 = 3'b011 each → `st_err` pulses once per request, nothing enqueued, `empty` stays 1, `dmem_write` stays 0.
- **Full with simultaneous pop.** With `DEPTH` = 2, enqueue 3 stores while holding off `dmem_resp`:
  - `st_ready` = 0 after 2 accepts.
  - Assert `dmem_resp` in the same cycle as the third `st_valid`: the store is not accepted that edge, and is accepted the next edge.
  - All 3 stores are written in FIFO order with correct pointer wrap.
- **Load conflict.** Queue SW at 0x4008, hold off `dmem_resp`, drive `ld_addr` = 0x400B → `ld_hit` = 1. With `ld_addr` = 0x400C → `ld_hit` = 0. After resp and pop, `ld_hit` = 0 for 0x400B.
- **Reset mid-write.** Assert `rst` = 0 while `dmem_write` = 1 with 2 entries queued → at the next edge, `dmem_write` = 0, `empty` = 1, `st_ready` = 1. A later `dmem_resp` pulse has no effect.
